instr_issue_unit: RTL and testbench

INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

---
 rtl/instr_issue_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_issue_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// Purpose : holds a host-loaded program and issues it to the decoder word by word, stalling on vector ops and following bne.
// Latency : one cycle from start to the first instr_valid; then one scalar instruction per cycle; taken branches add no bubble.
// Backpress: load_ready drops while running and once the program memory is full; vector ops stall issue until vec_done.
//
// Ports:
//   clk, rst            sole clock (rising edge); asynchronous active-low reset
//   load_valid/_data/
//   load_last/_ready    host program load handshake; load_last closes a program
//   start               single-cycle run request (ignored with no program loaded)
//   instr, instr_valid  registered instruction to the decoder and its issue strobe
//   is_not_vect, is_bne,
//   branch_immediate,
//   bne_taken           decoder / scalar-compare feedback for the issued instruction
//   vec_done            vector datapath finished the stalled vector instruction
//   pc                  word address of instr
//   busy, done          running (RUN or WAIT_VEC) / program ran off its end
module instr_issue_unit #(
   parameter int dwidth_inst = 32,
   parameter int depth_IM    = 256,
   localparam int aw         = $clog2(depth_IM)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   input  logic [dwidth_inst-1:0] load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   start,
   output logic [dwidth_inst-1:0] instr,
   output logic                   instr_valid,
   input  logic                   is_not_vect,
   input  logic                   is_bne,
   input  logic [11:0]            branch_immediate,
   input  logic                   bne_taken,
   input  logic                   vec_done,
   output logic [aw-1:0]          pc,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT_VEC, DONE} state_t;

   localparam logic [aw:0] DEPTH = (aw+1)'(depth_IM);

   state_t                 state_q, state_d;
   logic [aw-1:0]          pc_q, pc_d;
   logic [dwidth_inst-1:0] instr_q, instr_d;
   // Write pointer and program length carry one extra bit so a full memory
   // (depth_IM words) is representable.
   logic [aw:0]            wptr_q, wptr_d;
   logic [aw:0]            prog_len_q, prog_len_d;

   logic [dwidth_inst-1:0] im_q [depth_IM];

   logic                   load_hs;
   logic [aw:0]            wptr_inc;
   logic [aw:0]            pc_inc;
   logic [aw-1:0]          br_target;
   logic                   advance;
   logic [aw:0]            adv_pc;
   logic                   unused_bi0;

   // Branch offsets are in halfwords; bit 0 is dropped to get a word offset.
   assign unused_bi0 = branch_immediate[0];

   assign load_ready = ((state_q == IDLE) || (state_q == DONE)) && (wptr_q != DEPTH);
   assign load_hs    = load_valid && load_ready;
   assign wptr_inc   = wptr_q + (aw+1)'(1);

   // Sequential increment keeps the carry so running past the last word of a
   // full memory still terminates; branch targets wrap modulo depth_IM.
   assign pc_inc     = (aw+1)'(pc_q) + (aw+1)'(1);
   assign br_target  = pc_q + aw'($signed(branch_immediate[11:1]));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      wptr_d     = wptr_q;
      prog_len_d = prog_len_q;
      advance    = 1'b0;
      adv_pc     = pc_inc;

      case (state_q)
         IDLE, DONE: begin
            if (load_hs) begin
               // Any load activity leaves DONE so done drops with the handshake.
               state_d = IDLE;
               if (load_last) begin
                  prog_len_d = wptr_inc;
                  wptr_d     = '0;
               end else begin
                  wptr_d = wptr_inc;
                  if (wptr_inc == DEPTH) begin
                     prog_len_d = DEPTH;
                  end
               end
            end else if (start && (prog_len_q != '0)) begin
               pc_d    = '0;
               instr_d = im_q[0];
               state_d = RUN;
            end
         end
         RUN: begin
            if (!is_not_vect) begin
               state_d = WAIT_VEC;
            end else begin
               advance = 1'b1;
               if (is_bne && bne_taken) begin
                  adv_pc = (aw+1)'(br_target);
               end
            end
         end
         WAIT_VEC: begin
            if (vec_done) begin
               advance = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (adv_pc >= prog_len_q) begin
            state_d = DONE;
         end else begin
            pc_d    = adv_pc[aw-1:0];
            instr_d = im_q[adv_pc[aw-1:0]];
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         wptr_q     <= '0;
         prog_len_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         wptr_q     <= wptr_d;
         prog_len_q <= prog_len_d;
      end
   end

   // Program memory is not reset; a handshake only happens while wptr < depth_IM.
   always_ff @(posedge clk) begin
      if (load_hs) begin
         im_q[wptr_q[aw-1:0]] <= load_data;
      end
   end

   assign instr       = instr_q;
   assign pc          = pc_q;
   assign instr_valid = (state_q == RUN);
   assign busy        = (state_q == RUN) || (state_q == WAIT_VEC);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        start;
   logic [31:0] instr;
   logic        instr_valid;
   logic        is_not_vect;
   logic        is_bne;
   logic [11:0] branch_immediate;
   logic        bne_taken;
   logic        vec_done;
   logic [7:0]  pc;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [4];

   instr_issue_unit dut (
      .clk              (clk),
      .rst              (rst),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .start            (start),
      .instr            (instr),
      .instr_valid      (instr_valid),
      .is_not_vect      (is_not_vect),
      .is_bne           (is_bne),
      .branch_immediate (branch_immediate),
      .bne_taken        (bne_taken),
      .vec_done         (vec_done),
      .pc               (pc),
      .busy             (busy),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      chk("load_ready_before_word", 64'(load_ready), 64'd1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      prog[0] = 32'h0000_1013;
      prog[1] = 32'h0200_0057;
      prog[2] = 32'hFE00_1CE3;
      prog[3] = 32'h0000_0093;

      rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      start = 1'b0; is_not_vect = 1'b1; is_bne = 1'b0; branch_immediate = '0;
      bne_taken = 1'b0; vec_done = 1'b0;

      // Reset values
      repeat (2) tick();
      chk("rst_load_ready", 64'(load_ready), 64'd1);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      rst = 1'b1;
      tick();

      // start with no program is ignored
      pulse_start();
      chk("empty_start_valid", 64'(instr_valid), 64'd0);
      chk("empty_start_busy", 64'(busy), 64'd0);
      tick();
      chk("empty_start_valid2", 64'(instr_valid), 64'd0);

      // Four-word scalar program
      for (int i = 0; i < 4; i++) load_word(prog[i], (i == 3));
      chk("after_load_ready", 64'(load_ready), 64'd1);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         chk("seq_valid", 64'(instr_valid), 64'd1);
         chk("seq_pc", 64'(pc), 64'(i));
         chk("seq_instr", 64'(instr), 64'(prog[i]));
         chk("seq_busy", 64'(busy), 64'd1);
         chk("seq_load_ready", 64'(load_ready), 64'd0);
         tick();
      end
      chk("seq_done", 64'(done), 64'd1);
      chk("seq_done_busy", 64'(busy), 64'd0);
      chk("seq_done_valid", 64'(instr_valid), 64'd0);

      // Vector stall at pc 1, then bne taken / not taken at pc 2
      pulse_start();
      chk("vec_pc0", 64'(pc), 64'd0);
      chk("vec_start_done", 64'(done), 64'd0);
      tick();
      chk("vec_pc1", 64'(pc), 64'd1);
      chk("vec_pc1_valid", 64'(instr_valid), 64'd1);
      is_not_vect = 1'b0;
      tick();
      is_not_vect = 1'b1;
      chk("vec_wait_valid", 64'(instr_valid), 64'd0);
      chk("vec_wait_pc", 64'(pc), 64'd1);
      chk("vec_wait_instr", 64'(instr), 64'(prog[1]));
      chk("vec_wait_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("vec_hold_valid", 64'(instr_valid), 64'd0);
         chk("vec_hold_pc", 64'(pc), 64'd1);
      end
      vec_done = 1'b1;
      tick();
      vec_done = 1'b0;
      chk("vec_resume_valid", 64'(instr_valid), 64'd1);
      chk("vec_resume_pc", 64'(pc), 64'd2);
      chk("vec_resume_instr", 64'(instr), 64'(prog[2]));
      is_bne = 1'b1; bne_taken = 1'b1; branch_immediate = 12'hFFC;
      tick();
      is_bne = 1'b0; bne_taken = 1'b0;
      chk("bne_taken_pc", 64'(pc), 64'd0);
      chk("bne_taken_instr", 64'(instr), 64'(prog[0]));
      chk("bne_taken_valid", 64'(instr_valid), 64'd1);
      tick();
      chk("after_br_pc1", 64'(pc), 64'd1);
      tick();
      chk("after_br_pc2", 64'(pc), 64'd2);
      is_bne = 1'b1; bne_taken = 1'b0;
      tick();
      is_bne = 1'b0;
      chk("bne_not_taken_pc", 64'(pc), 64'd3);
      chk("bne_not_taken_instr", 64'(instr), 64'(prog[3]));
      tick();
      chk("prog2_done", 64'(done), 64'd1);
      vec_done = 1'b1;
      tick();
      vec_done = 1'b0;
      chk("stray_vec_done", 64'(done), 64'd1);
      chk("stray_vec_busy", 64'(busy), 64'd0);

      // Self-loop holds pc; forward branch past the end finishes
      pulse_start();
      is_bne = 1'b1; bne_taken = 1'b1; branch_immediate = 12'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("self_loop_pc", 64'(pc), 64'd0);
         chk("self_loop_valid", 64'(instr_valid), 64'd1);
      end
      branch_immediate = 12'h010;
      tick();
      is_bne = 1'b0; bne_taken = 1'b0;
      chk("br_out_done", 64'(done), 64'd1);
      chk("br_out_valid", 64'(instr_valid), 64'd0);

      // New two-word program overwrites from address 0; start during a load handshake is ignored
      load_word(32'hCAFE_0001, 1'b0);
      chk("reload_done_cleared", 64'(done), 64'd0);
      load_valid = 1'b1; load_data = 32'hCAFE_0002; load_last = 1'b1; start = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
      chk("start_with_load_busy", 64'(busy), 64'd0);
      chk("start_with_load_valid", 64'(instr_valid), 64'd0);
      pulse_start();
      chk("new_prog_pc0", 64'(pc), 64'd0);
      chk("new_prog_instr0", 64'(instr), 64'h0000_0000_CAFE_0001);
      tick();
      chk("new_prog_pc1", 64'(pc), 64'd1);
      chk("new_prog_instr1", 64'(instr), 64'h0000_0000_CAFE_0002);
      tick();
      chk("new_prog_done", 64'(done), 64'd1);

      // Reset while waiting on a vector instruction
      pulse_start();
      is_not_vect = 1'b0;
      tick();
      is_not_vect = 1'b1;
      chk("pre_rst_busy", 64'(busy), 64'd1);
      chk("pre_rst_valid", 64'(instr_valid), 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(instr_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_pc", 64'(pc), 64'd0);
      chk("mid_rst_instr", 64'(instr), 64'd0);
      chk("mid_rst_load_ready", 64'(load_ready), 64'd1);
      tick();
      rst = 1'b1;
      pulse_start();
      chk("post_rst_start_valid", 64'(instr_valid), 64'd0);
      chk("post_rst_start_busy", 64'(busy), 64'd0);
      tick();
      chk("post_rst_start_valid2", 64'(instr_valid), 64'd0);

      // Overfill: depth+2 words without load_last
      for (int i = 0; i < 258; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hA000_0000 + 32'(i);
         chk("fill_load_ready", 64'(load_ready), (i < 256) ? 64'd1 : 64'd0);
         tick();
      end
      load_valid = 1'b0;
      chk("full_load_ready", 64'(load_ready), 64'd0);
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         chk("full_run_pc", 64'(pc), 64'(i));
         chk("full_run_instr", 64'(instr), 64'(32'hA000_0000 + 32'(i)));
         tick();
      end
      chk("full_run_done", 64'(done), 64'd1);
      chk("full_run_busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
